// File: rtl/gpa_spi_engine.sv
// gpa_spi_engine: command-driven SPI master for a multi-channel DAC with
// optional ADC readback over the same SPI clock and data-out lines.
// Optional feature: define GPA_SPI_READBACK_EN to enable ADC readback
// commands; when it is undefined, ADC commands are rejected with err_o.
// Handshake: a command transfers on a rising clk edge where valid_i and
// ready_o are both 1. ready_o is 1 only in IDLE, and only once reset is released.
module gpa_spi_engine #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DIV_W-1:0]  spi_clk_div_i,
  output logic              spi_clk_o,
  output logic              spi_sdo_o,
  output logic              spi_csn_o,
  output logic              adc_csn_o,
  input  logic              spi_sdi_i,
  output logic [DATA_W-1:0] adc_value_o,
  output logic              adc_valid_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [2:0]        state_o
);

  localparam int FRAME_W = DATA_W + 8;
  localparam int SR_W    = 2 * DATA_W;
  localparam int BIT_W   = $clog2(SR_W);
  localparam logic [23:0]     SYNC24  = 24'h020000;
  localparam logic [SR_W-1:0] SYNC_SR = SR_W'(SYNC24[23 -: FRAME_W]) << (SR_W - FRAME_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             init_q, init_d;
  logic             err_q, err_d;
  logic             adc_q, adc_d;
  logic             cur_adc_q, cur_adc_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  load_sr_q, load_sr_d;
  logic [15:0]      shadow_q, shadow_d;
`ifdef GPA_SPI_READBACK_EN
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] adv_q, adv_d;
`endif

  // Command decode, evaluated only while a command is being accepted
  logic             is_adc, bcast, bad_ch, cmd_bad;
  logic [3:0]       ch, addr;
  logic [15:0]      payload16;
  logic [23:0]      frame24;
  logic [SR_W-1:0]  cmd_sr;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W:0]   half;
  logic             sample_pt;
  logic [BIT_W-1:0] last_bit;

  // Decode the command word and bit-period timing helpers
  always_comb begin
    is_adc    = data_i[30];
    bcast     = data_i[24];
    ch        = data_i[28:25];
    payload16 = 16'(data_i[DATA_W-1:0]) << (16 - DATA_W);
    if (bcast)         addr = 4'h6;
    else if (N_CH > 8) addr = ch;
    else               addr = {1'b1, ch[2:0]};
    frame24 = {4'h0, addr, payload16};
    bad_ch  = !bcast && ({1'b0, ch} >= 5'(N_CH));
`ifdef GPA_SPI_READBACK_EN
    cmd_bad = !is_adc && bad_ch;
`else
    cmd_bad = is_adc || bad_ch;
`endif
    cmd_sr    = is_adc ? (SR_W'(data_i[DATA_W-1:0]) << DATA_W)
                       : (SR_W'(frame24[23 -: FRAME_W]) << (SR_W - FRAME_W));
    div_lat   = (spi_clk_div_i == '0) ? DIV_W'(1) : spi_clk_div_i;
    half      = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    sample_pt = ({1'b0, cnt_q} == half - (DIV_W+1)'(1));
    last_bit  = cur_adc_q ? BIT_W'(SR_W - 1) : BIT_W'(FRAME_W - 1);
  end

  // Next-state logic: IDLE -> LOAD -> SHIFT -> GAP -> (LOAD | DONE) -> IDLE
  always_comb begin
    state_d   = state_q;
    init_d    = 1'b1;
    err_d     = 1'b0;
    adc_d     = adc_q;
    cur_adc_d = cur_adc_q;
    pend_d    = pend_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    load_sr_d = load_sr_q;
    shadow_d  = shadow_q;
`ifdef GPA_SPI_READBACK_EN
    cap_d     = cap_q;
    adv_d     = adv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i && ready_o) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d   = S_LOAD;
            adc_d     = is_adc;
            load_sr_d = cmd_sr;
            div_d     = div_lat;
            cnt_d     = '0;
          end
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        // The DAC needs one sync-register clear after reset before data frames
        if (shadow_q != 16'h0000) begin
          sr_d      = SYNC_SR;
          cur_adc_d = 1'b0;
          pend_d    = 1'b1;
          shadow_d  = 16'h0000;
        end else begin
          sr_d      = load_sr_q;
          cur_adc_d = adc_q;
          pend_d    = 1'b0;
        end
      end
      S_SHIFT: begin
`ifdef GPA_SPI_READBACK_EN
        if (cur_adc_q && (bit_q >= BIT_W'(DATA_W)) && sample_pt)
          cap_d = {cap_q[DATA_W-2:0], spi_sdi_i};
`endif
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (bit_q == last_bit) begin
            state_d = S_GAP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            sr_d  = sr_q << 1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          state_d = pend_q ? S_LOAD : S_DONE;
`ifdef GPA_SPI_READBACK_EN
          if (!pend_q && adc_q) adv_d = cap_q;
`endif
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame and re-arms the sync frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
      adc_q     <= 1'b0;
      cur_adc_q <= 1'b0;
      pend_q    <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      load_sr_q <= '0;
      shadow_q  <= 16'hFF00;
`ifdef GPA_SPI_READBACK_EN
      cap_q     <= '0;
      adv_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      err_q     <= err_d;
      adc_q     <= adc_d;
      cur_adc_q <= cur_adc_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      load_sr_q <= load_sr_d;
      shadow_q  <= shadow_d;
`ifdef GPA_SPI_READBACK_EN
      cap_q     <= cap_d;
      adv_q     <= adv_d;
`endif
    end
  end

  assign spi_clk_o = (state_q == S_SHIFT) && ({1'b0, cnt_q} < half);
  assign spi_sdo_o = (state_q == S_SHIFT) && sr_q[SR_W-1];
  assign spi_csn_o = !((state_q == S_SHIFT) && !cur_adc_q);
  assign ready_o   = init_q && (state_q == S_IDLE);
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;
  assign state_o   = state_q;
`ifdef GPA_SPI_READBACK_EN
  assign adc_csn_o   = !((state_q == S_SHIFT) && cur_adc_q);
  assign adc_valid_o = (state_q == S_DONE) && adc_q;
  assign adc_value_o = adv_q;
  logic unused_ok;
  assign unused_ok = ^{data_i[31], data_i[29], data_i[23:DATA_W], ch[3]};
`else
  assign adc_csn_o   = 1'b1;
  assign adc_valid_o = 1'b0;
  assign adc_value_o = '0;
  logic unused_ok;
  assign unused_ok = ^{data_i[31], data_i[29], data_i[23:DATA_W], ch[3], spi_sdi_i};
`endif

endmodule

// File: tb/tb_gpa_spi_engine.sv
// Directed bench for gpa_spi_engine (default parameters: 4 channels, 16-bit data).
module tb_gpa_spi_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic [5:0]  spi_clk_div_i = 6'd3;
  logic        spi_sdi_i;
  logic        ready_o, spi_clk_o, spi_sdo_o, spi_csn_o, adc_csn_o;
  logic [15:0] adc_value_o;
  logic        adc_valid_o, busy_o, err_o;
  logic [2:0]  state_o;

  gpa_spi_engine #(.N_CH(4), .DATA_W(16), .DIV_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .spi_clk_div_i(spi_clk_div_i), .spi_clk_o(spi_clk_o), .spi_sdo_o(spi_sdo_o),
    .spi_csn_o(spi_csn_o), .adc_csn_o(adc_csn_o), .spi_sdi_i(spi_sdi_i),
    .adc_value_o(adc_value_o), .adc_valid_o(adc_valid_o), .busy_o(busy_o),
    .err_o(err_o), .state_o(state_o)
  );

  // Clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected frames {bit count, bits} and chip-select low lengths
  logic [31:0] exp_q[$];
  int          exp_low_q[$];
  logic [31:0] obs_q[$];
  int          obs_low_q[$];
  logic [31:0] adc_obs_q[$];
  int          adc_low_q[$];

  // Bus monitor: samples at the falling clk edge, also plays the ADC sdi pattern
  logic [15:0] adc_pat = 16'h0000;
  logic [23:0] mon_sh;
  logic [31:0] mon_ash;
  int          mon_nb, mon_low, mon_anb, mon_alow;
  logic        prev_sclk, prev_csn, prev_acsn;
  int          err_cnt = 0;
  int          aval_cnt = 0;
  logic [15:0] last_aval = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_sh = '0; mon_ash = '0; mon_nb = 0; mon_low = 0; mon_anb = 0; mon_alow = 0;
      prev_sclk = 1'b0; prev_csn = 1'b1; prev_acsn = 1'b1; spi_sdi_i = 1'b0;
    end else begin
      if (spi_clk_o && !prev_sclk) begin
        if (!spi_csn_o) begin mon_sh = {mon_sh[22:0], spi_sdo_o}; mon_nb++; end
        if (!adc_csn_o) begin
          mon_ash = {mon_ash[30:0], spi_sdo_o};
          spi_sdi_i = (mon_anb >= 16) ? adc_pat[31 - mon_anb] : 1'b0;
          mon_anb++;
        end
      end
      if (!spi_csn_o) mon_low++;
      if (!adc_csn_o) mon_alow++;
      if (spi_csn_o && !prev_csn) begin
        obs_q.push_back({8'(mon_nb), mon_sh}); obs_low_q.push_back(mon_low);
        mon_sh = '0; mon_nb = 0; mon_low = 0;
      end
      if (adc_csn_o && !prev_acsn) begin
        adc_obs_q.push_back(mon_ash); adc_low_q.push_back(mon_alow);
        mon_ash = '0; mon_anb = 0; mon_alow = 0; spi_sdi_i = 1'b0;
      end
      if (err_o) err_cnt++;
      if (adc_valid_o) begin aval_cnt++; last_aval = adc_value_o; end
      prev_sclk = spi_clk_o; prev_csn = spi_csn_o; prev_acsn = adc_csn_o;
    end
  end

  // Driver: present one command and hold it until it is accepted
  task automatic send_cmd(input logic [31:0] cmd, input logic [5:0] div);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check_eq("ready_timeout", 32'(ready_o), 32'd1);
    data_i = cmd; spi_clk_div_i = div; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; data_i = '0;
  endtask

  task automatic measure_busy(input string tag, input int exp_len);
    int n = 0;
    while (busy_o && n < 5000) begin n++; @(negedge clk); end
    check_eq(tag, 32'(n), 32'(exp_len));
    @(negedge clk);
  endtask

  task automatic compare_frames(input string tag);
    check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check_eq({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
      check_eq({tag, "_csn_low"}, 32'(obs_low_q.pop_front()), 32'(exp_low_q.pop_front()));
    end
    exp_q.delete(); exp_low_q.delete(); obs_q.delete(); obs_low_q.delete();
  endtask

  int e0, v0;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 32'({spi_clk_o, spi_sdo_o, spi_csn_o, adc_csn_o,
                                   ready_o, busy_o, err_o, adc_valid_o}), 32'h30);
    check_eq("reset_adc_value", 32'(adc_value_o), 32'h0);
    check_eq("reset_state", 32'(state_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(ready_o), 32'd1);

    // First command: sync frame then data frame, busy never drops
    exp_q.push_back({8'd24, 24'h020000}); exp_low_q.push_back(96);
    exp_q.push_back({8'd24, 24'h081234}); exp_low_q.push_back(96);
    send_cmd(32'h0000_1234, 6'd3);
    measure_busy("cmd1_busy_len", 203);
    compare_frames("cmd1");

    // Channel 2, no sync frame any more
    exp_q.push_back({8'd24, 24'h0AABCD}); exp_low_q.push_back(96);
    send_cmd(32'h0400_ABCD, 6'd3);
    measure_busy("cmd2_busy_len", 102);
    compare_frames("cmd2");

    // Broadcast
    exp_q.push_back({8'd24, 24'h065555}); exp_low_q.push_back(96);
    send_cmd(32'h0100_5555, 6'd3);
    measure_busy("bcast_busy_len", 102);
    compare_frames("bcast");

    // Out-of-range channel 5 is dropped
    e0 = err_cnt;
    send_cmd(32'h0A00_0000, 6'd3);
    check_eq("badch_ready", 32'(ready_o), 32'd1);
    check_eq("badch_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check_eq("badch_err_pulses", 32'(err_cnt - e0), 32'd1);
    compare_frames("badch");

    // ADC readback
    adc_pat = 16'hBEEF;
    e0 = err_cnt; v0 = aval_cnt;
    send_cmd(32'h4000_8300, 6'd3);
`ifdef GPA_SPI_READBACK_EN
    measure_busy("adc_busy_len", 134);
    check_eq("adc_valid_pulses", 32'(aval_cnt - v0), 32'd1);
    check_eq("adc_value", 32'(last_aval), 32'hBEEF);
    check_eq("adc_value_held", 32'(adc_value_o), 32'hBEEF);
    check_eq("adc_frames", 32'(adc_obs_q.size()), 32'd1);
    if (adc_obs_q.size() > 0) begin
      check_eq("adc_sdo_bits", adc_obs_q.pop_front(), 32'h8300_0000);
      check_eq("adc_csn_low", 32'(adc_low_q.pop_front()), 32'd128);
    end
`else
    @(negedge clk);
    check_eq("adc_err_pulses", 32'(err_cnt - e0), 32'd1);
    check_eq("adc_no_frames", 32'(adc_obs_q.size()), 32'd0);
    check_eq("adc_no_valid", 32'(aval_cnt - v0), 32'd0);
    check_eq("adc_value_zero", 32'(adc_value_o), 32'h0);
`endif
    compare_frames("adc_dac_side");

    // Divider 0 is raised to 1: two-cycle bit period
    exp_q.push_back({8'd24, 24'h081234}); exp_low_q.push_back(48);
    send_cmd(32'h0000_1234, 6'd0);
    measure_busy("div0_busy_len", 52);
    compare_frames("div0");

    // Reset in the middle of a frame
    send_cmd(32'h0400_ABCD, 6'd3);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_outputs", 32'({spi_clk_o, spi_sdo_o, spi_csn_o, adc_csn_o,
                                      ready_o, busy_o, err_o, adc_valid_o}), 32'h30);
    check_eq("midreset_state", 32'(state_o), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midreset_ready", 32'(ready_o), 32'd1);
    compare_frames("midreset_aborted");

    // Sync frame must be repeated after the reset
    exp_q.push_back({8'd24, 24'h020000}); exp_low_q.push_back(96);
    exp_q.push_back({8'd24, 24'h0AABCD}); exp_low_q.push_back(96);
    send_cmd(32'h0400_ABCD, 6'd3);
    measure_busy("resync_busy_len", 203);
    compare_frames("resync");

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gpa_spi_engine.md
GPA_SPI_ENGINE -- requirements
Module: gpa_spi_engine

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of DAC channels, 1..16.
REQ-002 SHALL have parameter DATA_W, default 16: DAC code / ADC result width, 8..16; FRAME_W = DATA_W+8.
REQ-003 SHALL have parameter DIV_W, default 6: SPI divider width.
REQ-004 SHALL have port clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports data_i in 32 (command word), valid_i in 1, ready_o out 1 (valid/ready handshake).
REQ-007 SHALL have port spi_clk_div_i  in  DIV_W  bit period minus one, latched at accept.
REQ-008 SHALL have ports spi_clk_o, spi_sdo_o, spi_csn_o (DAC select), adc_csn_o out 1 each; spi_sdi_i in 1.
REQ-009 SHALL have ports adc_value_o out DATA_W, adc_valid_o out 1, busy_o out 1, err_o out 1.

Function
REQ-010 Command fields SHALL be: [DATA_W-1:0] payload, [24] broadcast, [28:25] channel, [30] ADC select; other bits ignored.
REQ-011 A command SHALL be accepted on a cycle with valid_i=1 and ready_o=1; ready_o=1 only in IDLE.
REQ-012 Latched divider SHALL be max(spi_clk_div_i,1); bit period P = div+1 cycles; divider counter restarts at 0 on accept.
REQ-013 Each bit SHALL drive spi_sdo_o MSB-first and raise spi_clk_o at counter 0; spi_clk_o falls at counter P/2 (floor).
REQ-014 FSM states SHALL be IDLE, LOAD, SHIFT, GAP, DONE; accept -> LOAD (1 cycle) -> SHIFT.
REQ-015 In LOAD, if shadow sync register != 16'h0000, the frame SHALL be {4'h0,4'h2,16'h0000}, shadow updated, and a data frame pending.
REQ-016 Otherwise the DAC frame SHALL be {4'h0, addr, payload left-justified to 16 bits}; addr = 4'h6 if broadcast else {1'b1,channel[2:0]} (N_CH>8: {1'b1,channel[3:0]} truncated to addr width per DAC map).
REQ-017 In SHIFT, the DAC select line SHALL be low for exactly FRAME_W bit periods, then the FSM enters GAP.
REQ-018 GAP SHALL hold both chip selects high and spi_sdo_o=0 for one bit period, then go to LOAD if a frame is pending, else to DONE.
REQ-019 DONE SHALL last 1 cycle, then go to IDLE.
REQ-020 busy_o SHALL be 1 from the cycle after accept through DONE inclusive.
REQ-021 A channel >= N_CH without broadcast SHALL cause the command to be dropped, err_o to pulse 1 cycle, and no SPI activity.
REQ-022 The ADC frame SHALL last 2*DATA_W bit periods with adc_csn_o low and spi_csn_o high; sdo carries payload for the first DATA_W bits, then 0.
REQ-023 In the ADC frame, spi_sdi_i SHALL be sampled on each falling spi_clk_o edge during bits DATA_W..2*DATA_W-1, shifted MSB-first.
REQ-024 adc_value_o SHALL update, and adc_valid_o pulse 1 cycle, in DONE of an ADC command.
REQ-025 spi_clk_o SHALL be 0 whenever not in SHIFT.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold regardless of state, aborting any frame: spi_clk_o=0, spi_sdo_o=0, spi_csn_o=1, adc_csn_o=1, ready_o=0, busy_o=0, err_o=0, adc_valid_o=0, adc_value_o=0, state=IDLE, shadow sync=16'hFF00.
REQ-027 ready_o SHALL be 1 on the first clock edge after rst_n rises.

Configuration
REQ-028 The macro GPA_SPI_READBACK_EN SHALL select readback support: defined, ADC commands behave per REQ-022..024.
REQ-029 With GPA_SPI_READBACK_EN undefined, ADC commands SHALL be dropped with a 1-cycle err_o pulse, adc_csn_o held 1, adc_value_o/adc_valid_o held 0, and capture logic removed.

Verification
REQ-030 First command after reset, 0x0000_1234 with div=3: sync frame 0x020000 is sent (24 periods of 4 cycles), followed by a GAP, then frame 0x081234; busy_o stays high throughout.
REQ-031 Second command, 0x0400_ABCD (channel 2): no sync frame, only 0x0AABCD; spi_csn_o is low for exactly 96 cycles.
REQ-032 Broadcast command 0x0100_5555: frame 0x065555 is sent.
REQ-033 Channel 5 with N_CH=4: err_o pulses once, spi_csn_o stays 1, and ready_o returns to 1 within 2 cycles.
REQ-034 ADC command 0x4000_8300 with spi_sdi_i pattern 0xBEEF (macro defined): adc_value_o=0xBEEF and adc_valid_o pulses once; without the macro, err_o pulses and no SPI activity occurs.
REQ-035 rst_n dropped mid-SHIFT: outputs take reset values immediately; the next command repeats the sync frame.
